imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writes a program image into the instruction memory, arriving as a byte stream.
- Assembles little-endian 32-bit words and issues one word write per 4 bytes.
- Holds the CPU in reset until the image is loaded.
- Sits between a byte source (UART RX or testbench) and the instruction memory write port.

Parameters:
ADDR_WIDTH, 8, word-address bits; memory depth = 2**ADDR_WIDTH words (256).
LEN_BYTES, 2, bytes in the little-endian length header (word count).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a load
byte_valid  in  1  byte_data valid
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts byte this cycle
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  32  byte address, word-aligned (bits [1:0]=0); memory indexes with address[31:2]
mem_wdata  out  32  assembled word
cpu_hold  out  1  keeps CPU in reset while loading
busy  out  1  load in progress
done  out  1  last load completed successfully
error  out  1  last load aborted on bad header

Behaviour:
- Reset (reset=0, async): state IDLE, all outputs 0, word counter 0, byte index 0, shift register 0.
- A byte transfers on a rising clk edge where byte_valid & byte_ready.
- byte_valid may be held across cycles; the loader never drops or duplicates a byte.
- State machine: IDLE, LEN, DATA, WRITE, DONE, ERR.
- IDLE: byte_ready=0. On start, go to LEN; clear done, error and counters.
- LEN: byte_ready=1. Accept LEN_BYTES bytes, LSB first, into len.
  - After the last length byte: if len==0 or len>2**ADDR_WIDTH, go to ERR.
  - Otherwise go to DATA.
- DATA: byte_ready=1. Bytes fill word little-endian: first byte -> [7:0], 4th byte -> [31:24].
  - On the 4th byte, go to WRITE.
- WRITE (exactly one cycle): byte_ready=0, mem_we=1, mem_addr={word_idx,2'b00} zero-extended to 32, mem_wdata=assembled word.
  - Then increment word_idx.
  - If word_idx+1==len, go to DONE; else go to DATA.
- Latency: 4th byte accepted at edge t -> mem_we high during cycle t..t+1; next byte accepted no earlier than edge t+2.
- DONE: done=1 (held), busy=0, cpu_hold=0. start -> LEN (new load, done cleared).
- ERR: error=1 (held), busy=0, cpu_hold=1 so the CPU never runs a partial image. start -> LEN.
- busy=1 in LEN, DATA, WRITE.
- cpu_hold=1 in LEN, DATA, WRITE, ERR. cpu_hold=0 in IDLE and DONE.
- start while busy: ignored, no restart.
- Bytes presented in IDLE/DONE/ERR: not accepted (byte_ready=0), no state change.
- Word count exactly 2**ADDR_WIDTH: accepted; last write to mem_addr 0x3FC (ADDR_WIDTH=8); word_idx does not wrap before DONE.
- reset asserted mid-load: immediate return to IDLE, mem_we deasserts asynchronously, partial word discarded.
- Only mem_we is a strobe; mem_addr and mem_wdata are don't-care when mem_we=0 but must be registered (no combinational path from byte_data).

Decomposition:
- Package imem_loader_pkg:
  - state enum (IDLE, LEN, DATA, WRITE, DONE, ERR)
  - constant BYTES_PER_WORD=4
  - function computing max word count from ADDR_WIDTH
- One natural sub-module: byte_packer. Accumulates 4 bytes into a little-endian word, has a 2-bit index, asserts word_full. Instantiated by imem_loader.
- The FSM and counters stay in the top module.

Test Plan:
- Basic load: start, bytes 02 00, then 13 00 00 00, 93 00 10 00 -> two mem_we pulses: addr 0x0 data 0x00000013, addr 0x4 data 0x00100093; then done=1, cpu_hold=0.
- Backpressure/gaps: same image with byte_valid toggled every other cycle, plus a byte presented during WRITE -> identical writes, byte held and accepted after WRITE, no loss or duplication.
- Bad header: header 00 00 -> error=1, cpu_hold=1, no mem_we. Header 01 01 (257 words) -> same result. Then start with a valid 1-word image -> error cleared, single write, done=1.
- Full depth: header 00 01 (256 words), word i = i -> 256 writes, last at addr 0x3FC data 0x000000FF, then done.
- Reset mid-load: reset low after 6 data bytes -> all outputs 0 immediately. New start plus 1-word image -> write at addr 0x0 with only new bytes.
- start ignored while busy: start pulsed during DATA -> load continues, word_idx not cleared, final write addresses unchanged.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [31:0] max_words(input int aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects stream bytes into a little-endian 32-bit word.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_full
);

    localparam int IW = $clog2(BYTES_PER_WORD);

    logic [IW-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (push) begin
            word[8*idx +: 8] <= data;
            idx              <= idx + 1'b1;
        end
    end

    assign word_full = push && (idx == IW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory,
// holding the CPU in reset until the whole image is written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_BYTES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int LW  = 8 * LEN_BYTES;
    localparam int LCW = $clog2(LEN_BYTES) + 1;

    state_t                state, state_d;
    logic [LW-1:0]         len, len_next;
    logic [LCW-1:0]        len_cnt;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           word;
    logic                  word_full;
    logic                  clr, len_en, push, widx_inc;
    logic                  len_last, len_bad, last_word;

    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clr),
        .push      (push),
        .data      (byte_data),
        .word      (word),
        .word_full (word_full)
    );

    // Header arrives LSB first, so each byte enters at the top.
    assign len_next  = (len >> 8) | (LW'(byte_data) << (LW - 8));
    assign len_last  = (len_cnt == LCW'(LEN_BYTES - 1));
    assign len_bad   = (len_next == '0) ||
                       (32'(len_next) > max_words(ADDR_WIDTH));
    assign last_word = (32'(word_idx) + 32'd1) == 32'(len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            len      <= '0;
            len_cnt  <= '0;
            word_idx <= '0;
        end else begin
            state <= state_d;
            if (clr) begin
                len      <= '0;
                len_cnt  <= '0;
                word_idx <= '0;
            end else begin
                if (len_en) begin
                    len     <= len_next;
                    len_cnt <= len_cnt + 1'b1;
                end
                if (widx_inc) begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state;
        clr      = 1'b0;
        len_en   = 1'b0;
        push     = 1'b0;
        widx_inc = 1'b0;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN;
                    clr     = 1'b1;
                end
            end
            LEN: begin
                if (byte_valid) begin
                    len_en = 1'b1;
                    if (len_last) begin
                        state_d = len_bad ? ERR : DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    push = 1'b1;
                    if (word_full) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                widx_inc = 1'b1;
                state_d  = last_word ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready = (state == LEN) || (state == DATA);
    assign busy       = byte_ready || (state == WRITE);
    assign cpu_hold   = busy || (state == ERR);
    assign done       = (state == DONE);
    assign error      = (state == ERR);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = {{(30 - ADDR_WIDTH){1'b0}}, word_idx, 2'b00};
    assign mem_wdata  = word;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader.
module tb_imem_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    wr_t         exp_q[$];
    wr_t         exp_w;
    int          tests = 0;
    int          fails = 0;
    int          gap_mode = 0;
    bit          tog = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && mem_we === 1'b1) begin
            check("ready_low_in_write", 64'(byte_ready), 64'd0);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h required none",
                         mem_addr, mem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("write", {mem_addr, mem_wdata}, {exp_w.addr, exp_w.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit pulse);
        int gap;
        int n;
        if (gap_mode == 0) gap = 0;
        else if (gap_mode == 1) begin
            tog = ~tog;
            gap = int'(tog);
        end else gap = $urandom_range(0, 2);
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            start = 1'b0;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        start = pulse;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!byte_ready) begin
            tests++;
            fails++;
            $display("FAIL byte_timeout: got ready 0 required 1");
        end
        @(posedge clk);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_image(input logic [31:0] words[$], input int hdr,
                              input int start_at);
        for (int i = 0; i < words.size(); i++)
            exp_q.push_back('{addr: 32'(4 * i), data: words[i]});
        do_start();
        send_byte(8'(hdr), 1'b0);
        send_byte(8'(hdr >> 8), 1'b0);
        for (int i = 0; i < words.size(); i++)
            for (int j = 0; j < 4; j++)
                send_byte(8'(words[i] >> (8 * j)), (4 * i + j) == start_at);
        idle_bus();
    endtask

    task automatic wait_end(input bit ok);
        int n;
        n = 0;
        while (!(done || error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done", 64'(done), 64'(ok));
        check("error", 64'(error), 64'(!ok));
        check("cpu_hold", 64'(cpu_hold), 64'(!ok));
        check("busy", 64'(busy), 64'd0);
        check("writes_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        check(name, {26'd0, byte_ready, mem_we, cpu_hold, busy, done, error,
                     mem_addr}, 64'd0);
        check({name, "_wdata"}, 64'(mem_wdata), 64'd0);
    endtask

    logic [31:0] w[$];

    initial begin
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset = 1'b1;

        // Bytes in IDLE are refused.
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_ready", {62'd0, byte_ready, busy}, 64'd0);
        byte_valid = 1'b0;

        w = '{32'h00000013, 32'h00100093};
        gap_mode = 0;
        load_image(w, 2, -1);
        wait_end(1'b1);

        gap_mode = 1;
        load_image(w, 2, -1);
        wait_end(1'b1);

        gap_mode = 2;
        w.delete();
        load_image(w, 0, -1);
        wait_end(1'b0);
        load_image(w, 257, -1);
        wait_end(1'b0);
        @(negedge clk);
        byte_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("err_ready", 64'(byte_ready), 64'd0);
        byte_valid = 1'b0;
        w = '{32'hDEADBEEF};
        load_image(w, 1, -1);
        wait_end(1'b1);

        gap_mode = 0;
        w.delete();
        for (int i = 0; i < 256; i++) w.push_back(32'(i));
        load_image(w, 256, -1);
        wait_end(1'b1);

        // Reset after six data bytes: first word written, rest discarded.
        exp_q.push_back('{addr: 32'h0, data: 32'h44332211});
        do_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 1; i <= 6; i++) send_byte(8'(8'h11 * i), 1'b0);
        #2 reset = 1'b0;
        #1 check_zero("midload_reset");
        check("midload_writes", 64'(exp_q.size()), 64'd0);
        byte_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        w = '{32'hA5A5C3C3};
        load_image(w, 1, -1);
        wait_end(1'b1);

        gap_mode = 2;
        w = '{32'h01020304, 32'h05060708, 32'h090A0B0C};
        load_image(w, 3, 5);
        wait_end(1'b1);

        for (int t = 0; t < 6; t++) begin
            int n;
            n = $urandom_range(1, 16);
            w.delete();
            for (int i = 0; i < n; i++) w.push_back($urandom);
            gap_mode = $urandom_range(0, 2);
            load_image(w, n, $urandom_range(0, 4 * n - 1));
            wait_end(1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
